// File: rtl/video2ram.sv
// video2ram: captures the active window of a decoded 24-bit RGB pixel stream
// into the line-buffer RAM using line-stride addressing, and pulses
// starttrigger once enough lines are buffered to release the output side.
// Optional feature: define VIDEO2RAM_TESTPATTERN_EN to replace the captured
// pixel data with 8 vertical colour bars.
module video2ram #(
  parameter int ADDR_BITS          = 15,
  parameter int H_CAPTURE_START    = 260,
  parameter int H_CAPTURE_PIXELS   = 640,
  parameter int V_CAPTURE_START    = 36,
  parameter int V_CAPTURE_LINES    = 480,
  parameter int BUFFER_LINE_LENGTH = 640,
  parameter int RAM_NUMWORDS       = 20480,
  parameter int TRIGGER_LINE       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pixel_valid,
  input  logic [23:0]          pixel_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  output logic [ADDR_BITS-1:0] wraddr,
  output logic [23:0]          wrdata,
  output logic                 wren,
  output logic                 starttrigger
);

  typedef enum logic [1:0] {WAIT_VSYNC, VBLANK, ACTIVE, DONE} state_t;

  localparam logic [11:0]          H_LO    = 12'(H_CAPTURE_START);
  localparam logic [11:0]          H_HI    = 12'(H_CAPTURE_START + H_CAPTURE_PIXELS);
  localparam logic [10:0]          V_START = 11'(V_CAPTURE_START);
  localparam logic [11:0]          V_LINES = 12'(V_CAPTURE_LINES);
  localparam logic [11:0]          TRIG    = 12'(TRIGGER_LINE);
  localparam logic [ADDR_BITS-1:0] STRIDE  = ADDR_BITS'(BUFFER_LINE_LENGTH);
  localparam logic [ADDR_BITS-1:0] RAM_END = ADDR_BITS'(RAM_NUMWORDS);
`ifdef VIDEO2RAM_TESTPATTERN_EN
  // Guard against a zero bar width when fewer than 8 pixels are captured.
  localparam logic [9:0] BAR_DIV = 10'((H_CAPTURE_PIXELS / 8 > 0) ? H_CAPTURE_PIXELS / 8 : 1);
`endif

  state_t                 state, state_nxt;
  logic                   hs_q, vs_q;
  logic                   hs_edge, vs_edge;
  logic [11:0]            x, x_nxt;
  logic [10:0]            y, y_nxt;
  logic [ADDR_BITS-1:0]   line_base, base_nxt, base_sum;
  logic [11:0]            lines_done, lines_nxt;
  logic                   wr_nxt, trig_nxt;
  logic [ADDR_BITS-1:0]   addr_nxt;
  logic [23:0]            data_nxt;

  // Counters, edge detection, FSM next state and the write decision for this cycle.
  // x_nxt/base_nxt are the values that belong to the pixel sampled now, so an
  // edge cycle already uses the new line's coordinates.
  always_comb begin
    hs_edge   = pixel_valid & hs_q & ~hsync_in;
    vs_edge   = pixel_valid & vs_q & ~vsync_in;
    x_nxt     = x;
    y_nxt     = y;
    state_nxt = state;
    base_nxt  = line_base;
    lines_nxt = lines_done;
    base_sum  = line_base + STRIDE;
    trig_nxt  = 1'b0;

    if (pixel_valid) begin
      if (hs_edge)       x_nxt = '0;
      else if (x != '1)  x_nxt = x + 12'd1;
    end

    if (vs_edge)                    y_nxt = '0;
    else if (hs_edge && (y != '1))  y_nxt = y + 11'd1;

    if (vs_edge) begin
      state_nxt = VBLANK;
    end else if (hs_edge) begin
      case (state)
        VBLANK: begin
          if (y_nxt == V_START) begin
            state_nxt = ACTIVE;
            base_nxt  = '0;
            lines_nxt = '0;
          end else if (y_nxt == '1) begin
            state_nxt = DONE;
          end
        end
        ACTIVE: begin
          lines_nxt = lines_done + 12'd1;
          base_nxt  = (base_sum == RAM_END) ? '0 : base_sum;
          trig_nxt  = (lines_nxt == TRIG);
          if ((lines_nxt == V_LINES) || (y_nxt == '1)) state_nxt = DONE;
        end
        default: ;
      endcase
    end

    wr_nxt   = pixel_valid && (state_nxt == ACTIVE) && (x_nxt >= H_LO) && (x_nxt < H_HI);
    addr_nxt = base_nxt + ADDR_BITS'(x_nxt - H_LO);
`ifdef VIDEO2RAM_TESTPATTERN_EN
    data_nxt = bar_colour(3'(10'(x_nxt - H_LO) / BAR_DIV));
`else
    data_nxt = pixel_in;
`endif
  end

`ifdef VIDEO2RAM_TESTPATTERN_EN
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
  endfunction
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= WAIT_VSYNC;
    else        state <= state_nxt;
  end

  // Sync history, position counters and line-buffer bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      lines_done <= '0;
    end else begin
      if (pixel_valid) begin
        hs_q <= hsync_in;
        vs_q <= vsync_in;
      end
      x          <= x_nxt;
      y          <= y_nxt;
      line_base  <= base_nxt;
      lines_done <= lines_nxt;
    end
  end

  // ---- output stage: RAM write port and trigger, one cycle after sampling ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wren         <= 1'b0;
      starttrigger <= 1'b0;
      wraddr       <= '0;
      wrdata       <= '0;
    end else begin
      wren         <= wr_nxt;
      starttrigger <= trig_nxt;
      if (wr_nxt) begin
        wraddr <= addr_nxt;
        wrdata <= data_nxt;
      end
    end
  end

endmodule

// File: tb/tb_video2ram.sv
// Directed testbench for video2ram: capture, stride wrap, trigger, pixel_valid
// gaps, mid-frame vsync and asynchronous reset. With VIDEO2RAM_TESTPATTERN_EN
// defined, the colour-bar data path is exercised as well.
module tb_video2ram;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [23:0]   pixel_in = '0;
  logic          hsync_in = 1'b1;
  logic          vsync_in = 1'b1;
  logic [AW-1:0] wraddr, wraddr1;
  logic [23:0]   wrdata, wrdata1;
  logic          wren, wren1, starttrigger, trig1;

  int vectors = 0;
  int miscompares = 0;
  int trig_cnt = 0;
  int trig1_cnt = 0;

  always #5 clock = ~clock;

  video2ram #(
    .ADDR_BITS(AW), .H_CAPTURE_START(2), .H_CAPTURE_PIXELS(4), .V_CAPTURE_START(1),
    .V_CAPTURE_LINES(3), .BUFFER_LINE_LENGTH(4), .RAM_NUMWORDS(8), .TRIGGER_LINE(2)
  ) u0 (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wraddr(wraddr), .wrdata(wrdata),
    .wren(wren), .starttrigger(starttrigger)
  );

  // Single captured line per frame: the trigger line is never reached.
  video2ram #(
    .ADDR_BITS(AW), .H_CAPTURE_START(2), .H_CAPTURE_PIXELS(4), .V_CAPTURE_START(1),
    .V_CAPTURE_LINES(1), .BUFFER_LINE_LENGTH(4), .RAM_NUMWORDS(8), .TRIGGER_LINE(2)
  ) u1 (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wraddr(wraddr1), .wrdata(wrdata1),
    .wren(wren1), .starttrigger(trig1)
  );

`ifdef VIDEO2RAM_TESTPATTERN_EN
  logic [AW-1:0] wraddr2;
  logic [23:0]   wrdata2;
  logic          wren2, trig2;
  logic [23:0]   mem2 [16];

  video2ram #(
    .ADDR_BITS(AW), .H_CAPTURE_START(2), .H_CAPTURE_PIXELS(8), .V_CAPTURE_START(1),
    .V_CAPTURE_LINES(3), .BUFFER_LINE_LENGTH(8), .RAM_NUMWORDS(16), .TRIGGER_LINE(2)
  ) u2 (
    .clock(clock), .reset(reset), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wraddr(wraddr2), .wrdata(wrdata2),
    .wren(wren2), .starttrigger(trig2)
  );

  always @(negedge clock) if (wren2) mem2[wraddr2] = wrdata2;
`endif

  always @(negedge clock) begin
    if (starttrigger) trig_cnt++;
    if (trig1)        trig1_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_data(input int ln, input int x);
`ifdef VIDEO2RAM_TESTPATTERN_EN
    logic [2:0] i;
    i = 3'(x - 2);
    return {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
`else
    return 24'(ln * 16 + x);
`endif
  endfunction

  // One video line of npix valid pixels; hsync low on pixel 0.
  // vs_at: pixel index carrying a vsync falling edge (-1 none).
  // base: expected write base for this line (-1 = no writes expected).
  // trig: starttrigger expected after pixel 0. gap: invalid cycle after each pixel.
  // rst_at: pixel after which reset is pulsed asynchronously (-1 none).
  task automatic line(input int ln, input int vs_at, input int base, input bit trig,
                      input bit gap, input int rst_at, input int npix);
    bit dead;
    dead = 1'b0;
    for (int x = 0; x < npix; x++) begin
      bit w;
      pixel_valid = 1'b1;
      hsync_in    = (x != 0);
      vsync_in    = (x != vs_at);
      pixel_in    = 24'(ln * 16 + x);
      @(posedge clock); #1;
      if (vs_at >= 0 && x >= vs_at) dead = 1'b1;
      w = !dead && base >= 0 && x >= 2 && x < 6;
      chk("wren", wren, w);
      chk("starttrigger", starttrigger, trig && x == 0);
      if (w) begin
        chk("wraddr", wraddr, base + x - 2);
        chk("wrdata", wrdata, exp_data(ln, x));
      end
      if (x == rst_at) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_wren", wren, 0);
        chk("rst_wraddr", wraddr, 0);
        chk("rst_wrdata", wrdata, 0);
        reset = 1'b1;
        dead  = 1'b1;
      end
      if (gap) begin
        pixel_valid = 1'b0;
        hsync_in    = 1'b0;
        vsync_in    = 1'b0;
        pixel_in    = 24'hABCDEF;
        @(posedge clock); #1;
        chk("gap_wren", wren, 0);
        if (w) chk("gap_wraddr_hold", wraddr, base + x - 2);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
      end
    end
  endtask

  initial begin
    #12;
    chk("reset_wren", wren, 0);
    chk("reset_wraddr", wraddr, 0);
    chk("reset_wrdata", wrdata, 0);
    chk("reset_trig", starttrigger, 0);
    #1 reset = 1'b1;

    // Basic capture, stride wrap on line 3, trigger, line 4 lands in DONE.
    line(0,  0, -1, 0, 0, -1, 8);
    line(1, -1,  0, 0, 0, -1, 8);
    line(2, -1,  4, 0, 0, -1, 8);
    line(3, -1,  0, 1, 0, -1, 8);
    line(4, -1, -1, 0, 0, -1, 8);

    // pixel_valid gaps on the first captured line.
    line(0,  0, -1, 0, 0, -1, 8);
    line(1, -1,  0, 0, 1, -1, 8);
    line(2, -1,  4, 0, 0, -1, 8);
    line(3, -1,  0, 1, 0, -1, 8);
    line(4, -1, -1, 0, 0, -1, 8);

    // vsync edge during captured line 2 aborts; next frame restarts at 0.
    line(0,  0, -1, 0, 0, -1, 8);
    line(1, -1,  0, 0, 0, -1, 8);
    line(2,  3,  4, 0, 0, -1, 8);
    line(1, -1,  0, 0, 0, -1, 8);
    line(2, -1,  4, 0, 0, -1, 8);
    line(3, -1,  0, 1, 0, -1, 8);
    line(4, -1, -1, 0, 0, -1, 8);

    // Reset mid-line: nothing written until the next vsync.
    line(0,  0, -1, 0, 0, -1, 8);
    line(1, -1,  0, 0, 0,  3, 8);
    line(2, -1, -1, 0, 0, -1, 8);
    line(3, -1, -1, 0, 0, -1, 8);
    line(0,  0, -1, 0, 0, -1, 8);
    line(1, -1,  0, 0, 0, -1, 8);
    line(2, -1,  4, 0, 0, -1, 8);
    line(3, -1,  0, 1, 0, -1, 8);
    line(4, -1, -1, 0, 0, -1, 8);

`ifdef VIDEO2RAM_TESTPATTERN_EN
    line(0,  0, -1, 0, 0, -1, 10);
    line(1, -1,  0, 0, 0, -1, 10);
    chk("bar0", mem2[0], 24'h000000);
    chk("bar1", mem2[1], 24'h0000FF);
    chk("bar2", mem2[2], 24'h00FF00);
    chk("bar3", mem2[3], 24'h00FFFF);
    chk("bar4", mem2[4], 24'hFF0000);
    chk("bar5", mem2[5], 24'hFF00FF);
    chk("bar6", mem2[6], 24'hFFFF00);
    chk("bar7", mem2[7], 24'hFFFFFF);
`endif

    pixel_valid = 1'b0;
    @(posedge clock); #1;
    chk("trigger_count", trig_cnt, 4);
    chk("trigger_count_vlines1", trig1_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/video2ram.md
# video2ram

Capture stage that sits directly upstream of the line-buffer RAM read by the output timing generator. It takes the Dreamcast pixel stream, already decoded to 24-bit RGB, together with its syncs. It locates the active window with horizontal and vertical counters and writes each active pixel into the dual-port RAM using the shared line-stride addressing. Once enough lines are buffered, it issues the `starttrigger` pulse that releases the output side.

## Interface
Parameters:
- `ADDR_BITS`, default 15: RAM address width (equals `RAM_ADDRESS_BITS`).
- `H_CAPTURE_START`, default 260: valid-pixel index, counted from the hsync falling edge, of the first captured pixel.
- `H_CAPTURE_PIXELS`, default 640: pixels captured per line; must be ≤ `BUFFER_LINE_LENGTH`.
- `V_CAPTURE_START`, default 36: line index, counted from the vsync falling edge, of the first captured line.
- `V_CAPTURE_LINES`, default 480: lines captured per frame.
- `BUFFER_LINE_LENGTH`, default 640: address stride per captured line.
- `RAM_NUMWORDS`, default 20480: RAM depth; must be a multiple of `BUFFER_LINE_LENGTH`.
- `TRIGGER_LINE`, default 16: captured-line count at which `starttrigger` fires.

Ports:
- `clock` in 1: capture clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `pixel_valid` in 1: qualifies `pixel_in`, `hsync_in` and `vsync_in` on this cycle.
- `pixel_in` in 24: {R,G,B}, 8 bits each.
- `hsync_in` in 1: active-low, synchronous to `clock`.
- `vsync_in` in 1: active-low, synchronous to `clock`.
- `wraddr` out `ADDR_BITS`: RAM write address.
- `wrdata` out 24: RAM write data.
- `wren` out 1: RAM write enable.
- `starttrigger` out 1: one-cycle pulse, once per frame.

## Operation
- Sync inputs and pixels are sampled only on `pixel_valid`=1 cycles. `hs_q` and `vs_q` hold the last sampled values and reset to 1.
- hsync falling edge: a valid cycle with `hs_q`=1 and `hsync_in`=0. The same definition applies to vsync.
- `x` (12 bit) counts valid cycles:
  - The edge cycle is `x`=0; each further valid cycle adds 1.
  - `x` saturates at 4095.
- `y` (11 bit) increments on each hsync edge and saturates at 2047.
- A vsync edge sets `y`=0. It also forces `x`=0 when it coincides with an hsync edge.
- State machine, reset state `WAIT_VSYNC`:
  - `WAIT_VSYNC`: no writes. A vsync edge moves to `VBLANK`.
  - `VBLANK`: no writes. On the hsync edge that sets `y`=`V_CAPTURE_START`, move to `ACTIVE`, with `line_base`=0 and `lines_done`=0.
  - `ACTIVE`: a write occurs on each valid cycle with `H_CAPTURE_START` ≤ `x` < `H_CAPTURE_START`+`H_CAPTURE_PIXELS`. Write address is `line_base` + (`x` − `H_CAPTURE_START`).
  - On each hsync edge in `ACTIVE`:
    - `lines_done` += 1.
    - `line_base` += `BUFFER_LINE_LENGTH`; when the result equals `RAM_NUMWORDS`, `line_base` wraps to 0.
    - When `lines_done` reaches `V_CAPTURE_LINES`, move to `DONE`.
  - `DONE`: no writes. A vsync edge moves to `VBLANK`.
- A vsync edge in any state other than `WAIT_VSYNC` aborts the frame and moves to `VBLANK`. A partial line already written stays in RAM.
- `starttrigger` pulses for one cycle in the cycle after `lines_done` becomes `TRIGGER_LINE`. It fires at most once per frame.
- If `y` saturates with no vsync (missing vsync), the block stays in `DONE` until the next vsync.

## Timing
- Reset values: `wren`=0, `wraddr`=0, `wrdata`=0, `starttrigger`=0, state `WAIT_VSYNC`, `x`=`y`=0, `line_base`=0, `lines_done`=0.
- Latency: all outputs are registered. A pixel sampled in cycle N appears as `wrdata`, `wraddr` and `wren`=1 in cycle N+1.
- When `pixel_valid`=0 in cycle N, `wren` is 0 in cycle N+1; `wraddr` and `wrdata` hold their values.
- No handshake exists on the RAM port. A write is assumed to complete in one cycle.
- Reset asserted mid-line clears all outputs immediately (asynchronously). After release, capture resumes at the next vsync edge.

## Configuration
- `VIDEO2RAM_TESTPATTERN_EN` defined: `wrdata` ignores `pixel_in` and carries 8 vertical colour bars.
  - Bar index = (`x` − `H_CAPTURE_START`)[9:0] / (`H_CAPTURE_PIXELS`/8).
  - Colour = {8{index[2]}, 8{index[1]}, 8{index[0]}}, i.e. bar 0 is black and bar 7 is white.
  - Addressing, `wren` and trigger behaviour are unchanged.
- Macro undefined: `wrdata` = `pixel_in`, registered.

## Test plan
Unless stated otherwise, the bench uses `H_CAPTURE_START`=2, `H_CAPTURE_PIXELS`=4, `V_CAPTURE_START`=1, `V_CAPTURE_LINES`=3, `BUFFER_LINE_LENGTH`=4, `RAM_NUMWORDS`=8, `TRIGGER_LINE`=2, and lines of 8 valid pixels.
- Basic capture: vsync edge, then 4 hsync lines with `pixel_in`=line×16+x -> `wraddr` 0..3 carry 0x12..0x15; `wraddr` 4..7 carry 0x22..0x25; line 0 is not written.
- Wrap-around: third captured line -> `wraddr` 0..3 carry 0x32..0x35. A fourth line produces no `wren`, because the state is `DONE`.
- Trigger: exactly one `starttrigger` pulse per frame, 1 cycle after the hsync edge that ends captured line 2. No pulse occurs over 2 frames when `V_CAPTURE_LINES`=1.
- `pixel_valid` gaps: pixel_valid toggles 1,0,1,… -> `wren` only in cycles following valid cycles; addresses stay contiguous 0..3.
- Mid-frame vsync and reset: a vsync edge during captured line 2 -> the next write is at `wraddr` 0 of the following frame. Asserting `reset` mid-line -> `wren`=0 in the same cycle, and no writes occur before the next vsync.
- `VIDEO2RAM_TESTPATTERN_EN` with `H_CAPTURE_PIXELS`=8 and `BUFFER_LINE_LENGTH`=8 -> `wrdata` sequence 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF.
